// File: rtl/agc_gain_apply.sv
// rtl/agc_gain_apply.sv - AGC actuator: boundary-safe gain update, I/Q scale, round, saturate, clip count
module agc_gain_apply #(
    parameter int W_IN     = 16,
    parameter int W_OUT    = 16,
    parameter int W_GAIN   = 16,
    parameter int F_GAIN   = 12,
    parameter int HOLD_MAX = 8,
    parameter int W_SATCNT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [W_GAIN-1:0]   i_gain,
    input  logic                i_gain_valid,
    output logic                o_gain_ready,
    input  logic [W_IN-1:0]     s_chans_dataI,
    input  logic [W_IN-1:0]     s_chans_dataQ,
    input  logic                s_chans_valid,
    output logic [W_OUT-1:0]    m_chans_dataI,
    output logic [W_OUT-1:0]    m_chans_dataQ,
    output logic                m_chans_valid,
    output logic [W_GAIN-1:0]   o_gain_active,
    output logic [W_SATCNT-1:0] o_sat_count,
    input  logic                i_sat_clear
);

    // Product of a signed sample and a zero-extended (non-negative) gain.
    // Its magnitude stays below 2^(W_PROD-2), so adding the rounding
    // constant cannot overflow even at maximum gain.
    localparam int W_PROD = W_IN + W_GAIN + 1;
    localparam int W_HOLD = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [W_GAIN-1:0]        GAIN_UNITY = W_GAIN'(64'd1 << F_GAIN);
    localparam logic [W_HOLD-1:0]        HOLD_LAST  = W_HOLD'(HOLD_MAX - 1);
    localparam logic signed [W_PROD-1:0] RND        = W_PROD'(64'sd1 <<< (F_GAIN - 1));
    localparam logic signed [W_PROD-1:0] OUT_MAX    = W_PROD'((64'sd1 <<< (W_OUT - 1)) - 64'sd1);
    localparam logic signed [W_PROD-1:0] OUT_MIN    = ~OUT_MAX;
    localparam logic [W_SATCNT-1:0]      SAT_FULL   = '1;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [W_GAIN-1:0]   pending_gain;
    logic [W_GAIN-1:0]   gain_active;
    logic [W_HOLD-1:0]   hold_cnt;
    logic                capture;
    logic                load;

    logic [W_IN-1:0]            s1_i;
    logic [W_IN-1:0]            s1_q;
    logic [W_GAIN-1:0]          s1_gain;
    logic                       s1_valid;
    logic signed [W_PROD-1:0]   prod_i;
    logic signed [W_PROD-1:0]   prod_q;
    logic signed [W_PROD-1:0]   s2_pi;
    logic signed [W_PROD-1:0]   s2_pq;
    logic                       s2_valid;
    logic [W_OUT:0]             res_i;
    logic [W_OUT:0]             res_q;
    logic                       m_sat;
    logic [W_SATCNT-1:0]        sat_count;

    // Round half toward +inf, drop the fraction, clamp to output range.
    // Bit W_OUT of the result flags a clipped sample.
    function automatic logic [W_OUT:0] round_sat(input logic signed [W_PROD-1:0] p);
        logic signed [W_PROD-1:0] r;
        r = (p + RND) >>> F_GAIN;
        if (r > OUT_MAX) begin
            round_sat = {1'b1, OUT_MAX[W_OUT-1:0]};
        end else if (r < OUT_MIN) begin
            round_sat = {1'b1, OUT_MIN[W_OUT-1:0]};
        end else begin
            round_sat = {1'b0, r[W_OUT-1:0]};
        end
    endfunction

    // Gain FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gain FSM: accept in IDLE, swap in on an input gap or after the hold limit
    always_comb begin
        state_nxt    = state;
        capture      = 1'b0;
        load         = 1'b0;
        o_gain_ready = 1'b0;
        case (state)
            IDLE: begin
                o_gain_ready = 1'b1;
                if (i_gain_valid) begin
                    capture   = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (!s_chans_valid || hold_cnt == HOLD_LAST) begin
                    load      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending gain, hold counter and active gain registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_gain <= '0;
            hold_cnt     <= '0;
            gain_active  <= GAIN_UNITY;
        end else begin
            if (capture) begin
                pending_gain <= i_gain;
                hold_cnt     <= '0;
            end else if (state == PENDING) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (load) begin
                gain_active <= pending_gain;
            end
        end
    end

    // S1: capture the sample together with the gain in force this cycle,
    // so I and Q of one sample always share the same gain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_i     <= '0;
            s1_q     <= '0;
            s1_gain  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_i     <= s_chans_dataI;
            s1_q     <= s_chans_dataQ;
            s1_gain  <= gain_active;
            s1_valid <= s_chans_valid;
        end
    end

    assign prod_i = $signed({{(W_GAIN + 1){s1_i[W_IN-1]}}, s1_i}) * $signed({{W_IN{1'b0}}, 1'b0, s1_gain});
    assign prod_q = $signed({{(W_GAIN + 1){s1_q[W_IN-1]}}, s1_q}) * $signed({{W_IN{1'b0}}, 1'b0, s1_gain});

    // S2: full-precision products
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_pi    <= '0;
            s2_pq    <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_pi    <= prod_i;
            s2_pq    <= prod_q;
            s2_valid <= s1_valid;
        end
    end

    assign res_i = round_sat(s2_pi);
    assign res_q = round_sat(s2_pq);

    // S3: rounded, saturated outputs; data holds between valid samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_chans_dataI <= '0;
            m_chans_dataQ <= '0;
            m_chans_valid <= 1'b0;
            m_sat         <= 1'b0;
        end else begin
            if (s2_valid) begin
                m_chans_dataI <= res_i[W_OUT-1:0];
                m_chans_dataQ <= res_q[W_OUT-1:0];
            end
            m_chans_valid <= s2_valid;
            m_sat         <= s2_valid & (res_i[W_OUT] | res_q[W_OUT]);
        end
    end

    // Clip counter: one count per clipped output sample, sticky at full scale, clear wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count <= '0;
        end else if (i_sat_clear) begin
            sat_count <= '0;
        end else if (m_chans_valid && m_sat && sat_count != SAT_FULL) begin
            sat_count <= sat_count + 1'b1;
        end
    end

    assign o_gain_active = gain_active;
    assign o_sat_count   = sat_count;

endmodule

// File: tb/tb_agc_gain_apply.sv
// tb/tb_agc_gain_apply.sv - self-checking bench for agc_gain_apply
module tb_agc_gain_apply;

    localparam int HOLD = 8;
    localparam int NMAX = 336;

    logic        clk;
    logic        reset;
    logic [15:0] i_gain;
    logic        i_gain_valid;
    logic        o_gain_ready;
    logic [15:0] s_i;
    logic [15:0] s_q;
    logic        s_valid;
    logic [15:0] m_i;
    logic [15:0] m_q;
    logic        m_valid;
    logic [15:0] o_gain_active;
    logic [15:0] o_sat_count;
    logic        i_sat_clear;

    logic        ready2;
    logic [15:0] m2_i;
    logic [15:0] m2_q;
    logic        m2_valid;
    logic [15:0] gain2;
    logic [2:0]  sat2;

    agc_gain_apply dut (
        .clk(clk), .reset(reset),
        .i_gain(i_gain), .i_gain_valid(i_gain_valid), .o_gain_ready(o_gain_ready),
        .s_chans_dataI(s_i), .s_chans_dataQ(s_q), .s_chans_valid(s_valid),
        .m_chans_dataI(m_i), .m_chans_dataQ(m_q), .m_chans_valid(m_valid),
        .o_gain_active(o_gain_active), .o_sat_count(o_sat_count), .i_sat_clear(i_sat_clear)
    );

    agc_gain_apply #(.W_SATCNT(3)) dut_small (
        .clk(clk), .reset(reset),
        .i_gain(i_gain), .i_gain_valid(i_gain_valid), .o_gain_ready(ready2),
        .s_chans_dataI(s_i), .s_chans_dataQ(s_q), .s_chans_valid(s_valid),
        .m_chans_dataI(m2_i), .m_chans_dataQ(m2_q), .m_chans_valid(m2_valid),
        .o_gain_active(gain2), .o_sat_count(sat2), .i_sat_clear(i_sat_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int g;
        int i;
        int q;
        int ei;
        int eq;
        int esat;
    } vec_t;
    vec_t tbl[10];

    bit     vin[NMAX];
    int     vi[NMAX];
    int     vq[NMAX];
    bit     gv[NMAX];
    int     gval[NMAX];
    bit     e_ready[NMAX];
    int     e_gain[NMAX];
    bit     e_mv[NMAX];
    longint e_mi[NMAX];
    longint e_mq[NMAX];
    int     e_cnt[NMAX];
    bit     o_ready[NMAX];
    int     o_gain[NMAX];
    longint o_mi[NMAX];
    longint o_mq[NMAX];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        i_gain       = '0;
        i_gain_valid = 1'b0;
        s_i          = '0;
        s_q          = '0;
        s_valid      = 1'b0;
        i_sat_clear  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference: real-valued scaling, rounded half up, clamped to 16 bits
    task automatic ref_scale(input int x, input int g, output longint y, output bit clip);
        real r;
        r    = $floor((real'(x) * real'(g)) / 4096.0 + 0.5);
        clip = 1'b0;
        if (r > 32767.0) begin
            y    = 32767;
            clip = 1'b1;
        end else if (r < -32768.0) begin
            y    = -32768;
            clip = 1'b1;
        end else begin
            y = longint'(r);
        end
    endtask

    task automatic clear_arrays();
        for (int t = 0; t < NMAX; t++) begin
            vin[t]  = 1'b0;
            vi[t]   = 0;
            vq[t]   = 0;
            gv[t]   = 1'b0;
            gval[t] = 0;
        end
    endtask

    // Expected per-cycle behaviour from the stimulus arrays: a gain offered
    // while ready takes over on the first input gap within the hold window,
    // otherwise at the end of the window; outputs follow inputs by 3 cycles.
    task automatic build_model(input int T);
        int     cur;
        int     last_busy;
        int     newg;
        int     cnt;
        longint hi;
        longint hq;
        bit     ci;
        bit     cq;
        cur = 4096; last_busy = -1; newg = 0; cnt = 0; hi = 0; hq = 0;
        for (int t = 0; t < T; t++) begin
            e_ready[t] = (t > last_busy);
            e_gain[t]  = cur;
            if (t == last_busy) cur = newg;
            if (e_ready[t] && gv[t]) begin
                newg      = gval[t];
                last_busy = t + HOLD;
                for (int s = t + 1; s <= t + HOLD; s++) begin
                    if (!vin[s]) begin
                        last_busy = s;
                        break;
                    end
                end
            end
        end
        for (int t = 0; t < T; t++) begin
            e_cnt[t] = cnt;
            ci = 1'b0;
            cq = 1'b0;
            e_mv[t] = (t >= 3) && vin[t >= 3 ? t - 3 : 0];
            if (e_mv[t]) begin
                ref_scale(vi[t-3], e_gain[t-3], hi, ci);
                ref_scale(vq[t-3], e_gain[t-3], hq, cq);
            end
            e_mi[t] = hi;
            e_mq[t] = hq;
            if (e_mv[t] && (ci || cq) && cnt < 65535) cnt++;
        end
    endtask

    task automatic run_seq(input string tag, input int T);
        build_model(T);
        do_reset();
        for (int t = 0; t < T; t++) begin
            s_valid      = vin[t];
            s_i          = 16'(vi[t]);
            s_q          = 16'(vq[t]);
            i_gain_valid = gv[t];
            i_gain       = 16'(gval[t]);
            o_ready[t]   = o_gain_ready;
            o_gain[t]    = int'(o_gain_active);
            o_mi[t]      = longint'($signed(m_i));
            o_mq[t]      = longint'($signed(m_q));
            chk($sformatf("%s ready@%0d", tag, t), o_gain_ready, e_ready[t]);
            chk($sformatf("%s gain@%0d", tag, t), o_gain_active, e_gain[t]);
            chk($sformatf("%s mvalid@%0d", tag, t), m_valid, e_mv[t]);
            chk($sformatf("%s dataI@%0d", tag, t), longint'($signed(m_i)), e_mi[t]);
            chk($sformatf("%s dataQ@%0d", tag, t), longint'($signed(m_q)), e_mq[t]);
            chk($sformatf("%s satcnt@%0d", tag, t), o_sat_count, e_cnt[t]);
            tick();
        end
        s_valid      = 1'b0;
        i_gain_valid = 1'b0;
    endtask

    task automatic load_gain(input int g);
        int k;
        k       = 0;
        s_valid = 1'b0;
        while (!o_gain_ready && k < 20) begin
            tick();
            k++;
        end
        chk("gain_ready_wait", o_gain_ready, 1);
        i_gain       = 16'(g);
        i_gain_valid = 1'b1;
        tick();
        i_gain_valid = 1'b0;
        tick();
        chk("gain_loaded", o_gain_active, g);
    endtask

    task automatic send_sample(input int i, input int q, output longint oi, output longint oq, output int lat);
        s_i     = 16'(i);
        s_q     = 16'(q);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        lat     = 1;
        while (!m_valid && lat < 10) begin
            tick();
            lat++;
        end
        oi = longint'($signed(m_i));
        oq = longint'($signed(m_q));
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        longint oi;
        longint oq;
        int     lat;
        int     r;

        tbl[0] = '{4096,   1000,  -1000,  1000,  -1000, 0};
        tbl[1] = '{8192,  20000, -20000, 32767, -32768, 1};
        tbl[2] = '{8192,  20000, -20000, 32767, -32768, 2};
        tbl[3] = '{2048,      3,     -3,     2,     -1, 2};
        tbl[4] = '{2048,      1,     -1,     1,      0, 2};
        tbl[5] = '{0,     12345,     -5,     0,      0, 2};
        tbl[6] = '{65535,     1,     -1,    16,    -16, 2};
        tbl[7] = '{65535, 32767, -32768, 32767, -32768, 3};
        tbl[8] = '{6144,   1000,  -1001,  1500,  -1501, 3};
        tbl[9] = '{4096, -32768,  32767, -32768,  32767, 3};

        // Reset values
        do_reset();
        chk("rst_mvalid", m_valid, 0);
        chk("rst_dataI", m_i, 0);
        chk("rst_dataQ", m_q, 0);
        chk("rst_gain_active", o_gain_active, 4096);
        chk("rst_gain_ready", o_gain_ready, 1);
        chk("rst_sat_count", o_sat_count, 0);

        // Unity gain sample straight after reset: latency 3
        send_sample(1000, -1000, oi, oq, lat);
        chk("unity_latency", lat, 3);
        chk("unity_I", oi, 1000);
        chk("unity_Q", oq, -1000);

        // Table of gain / sample / expected result
        do_reset();
        for (int v = 0; v < 10; v++) begin
            load_gain(tbl[v].g);
            send_sample(tbl[v].i, tbl[v].q, oi, oq, lat);
            chk($sformatf("tbl%0d_latency", v), lat, 3);
            chk($sformatf("tbl%0d_I", v), oi, tbl[v].ei);
            chk($sformatf("tbl%0d_Q", v), oq, tbl[v].eq);
            tick();
            tick();
            chk($sformatf("tbl%0d_sat", v), o_sat_count, tbl[v].esat);
        end

        // Reset with samples in flight, output valid high and a gain pending
        s_i = 16'(20000); s_q = 16'(100); s_valid = 1'b1;
        i_gain = 16'(8192); i_gain_valid = 1'b1;
        tick();
        i_gain_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_mvalid", m_valid, 1);
        chk("pre_rst_ready", o_gain_ready, 0);
        reset = 1'b1;
        #1;
        chk("async_rst_mvalid", m_valid, 0);
        chk("async_rst_gain", o_gain_active, 4096);
        chk("async_rst_ready", o_gain_ready, 1);
        chk("async_rst_sat", o_sat_count, 0);
        s_valid = 1'b0;
        #1;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("post_rst_mvalid%0d", k), m_valid, 0);
            chk($sformatf("post_rst_gain%0d", k), o_gain_active, 4096);
            chk($sformatf("post_rst_ready%0d", k), o_gain_ready, 1);
        end

        // Clear wins over a simultaneous clipped output; counters stick at full scale
        load_gain(8192);
        send_sample(20000, 0, oi, oq, lat);
        tick();
        chk("clr_pre_count", o_sat_count, 1);
        s_i = 16'(20000); s_q = 16'(0); s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        chk("clr_mvalid", m_valid, 1);
        i_sat_clear = 1'b1;
        tick();
        i_sat_clear = 1'b0;
        chk("clr_same_cycle", o_sat_count, 0);
        tick();
        chk("clr_stays", o_sat_count, 0);
        chk("clr_small", sat2, 0);
        s_i = 16'(-20000); s_valid = 1'b1;
        repeat (10) tick();
        s_valid = 1'b0;
        repeat (6) tick();
        chk("sat_count_ten", o_sat_count, 10);
        chk("sat_sticky_small", sat2, 7);

        // Continuous input, gain offered in cycle 10: forced load after hold window
        clear_arrays();
        for (int t = 0; t < 30; t++) begin
            vin[t] = 1'b1;
            vi[t]  = 1000;
            vq[t]  = -2000;
        end
        gv[10] = 1'b1; gval[10] = 6144;
        run_seq("forced", 40);
        chk("forced_ready10", o_ready[10], 1);
        for (int t = 11; t <= 18; t++) chk($sformatf("forced_ready%0d", t), o_ready[t], 0);
        chk("forced_ready19", o_ready[19], 1);
        chk("forced_gain18", o_gain[18], 4096);
        chk("forced_gain19", o_gain[19], 6144);
        chk("forced_I21", o_mi[21], 1000);
        chk("forced_I22", o_mi[22], 1500);
        chk("forced_Q22", o_mq[22], -3000);

        // Same with an input gap at cycle 13
        vin[13] = 1'b0;
        run_seq("gap", 40);
        chk("gap_ready13", o_ready[13], 0);
        chk("gap_gain13", o_gain[13], 4096);
        chk("gap_gain14", o_gain[14], 6144);
        chk("gap_ready14", o_ready[14], 1);

        // Randomised traffic against the reference
        clear_arrays();
        for (int t = 0; t < 290; t++) begin
            vin[t] = ($urandom_range(0, 9) < 8);
            vi[t]  = int'($urandom_range(0, 65535)) - 32768;
            vq[t]  = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 7) == 0) vi[t] = -32768;
            if ($urandom_range(0, 7) == 0) vq[t] = 32767;
            gv[t] = ($urandom_range(0, 7) == 0);
            r = int'($urandom_range(0, 4));
            case (r)
                0:       gval[t] = 0;
                1:       gval[t] = 65535;
                2:       gval[t] = 4096;
                3:       gval[t] = int'($urandom_range(0, 16383));
                default: gval[t] = int'($urandom_range(0, 65535));
            endcase
        end
        run_seq("rand", 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
